// File: rtl/cache_memory_bus_pkg.sv
// Shared types and AXI burst constants for the cache-to-system-bus bridge.
package cache_memory_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_e;

  localparam int          LINE_BEATS  = 16;
  localparam int          LINE_OFFSET = 7;
  localparam logic [7:0]  AXI_LEN     = 8'd15;
  localparam logic [2:0]  AXI_SIZE    = 3'd3;
  localparam logic [1:0]  BURST_INCR  = 2'b01;

  function automatic logic [1:0] client_onehot(input logic client);
    return client ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cache_memory_bus_if.sv
// Client command/response signals plus the AXI4 master channels (AW/W/B/AR/R/AC).
interface cache_memory_bus_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  import cache_memory_bus_pkg::*;

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LINE       = LINE_BEATS * DATA_WIDTH;

  logic [1:0]              command_valid;
  logic [1:0]              command_store;
  logic [1:0]              command_rready;
  logic [2*ADDR_WIDTH-1:0] command_addr;
  logic [2*LINE-1:0]       data_in;
  logic [1:0]              bus_valid;
  logic [1:0]              bus_ready;
  logic [LINE-1:0]         data_out;
  logic                    invalidate;
  logic [ADDR_WIDTH-1:0]   invalidate_addr;

  logic [ID_WIDTH-1:0]     m_axi_awid;
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awlock;
  logic [3:0]              m_axi_awcache;
  logic [2:0]              m_axi_awprot;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [STRB_WIDTH-1:0]   m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [ID_WIDTH-1:0]     m_axi_bid;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  logic [ID_WIDTH-1:0]     m_axi_arid;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arlock;
  logic [3:0]              m_axi_arcache;
  logic [2:0]              m_axi_arprot;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [ID_WIDTH-1:0]     m_axi_rid;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;
  logic                    m_axi_acvalid;
  logic [ADDR_WIDTH-1:0]   m_axi_acaddr;
  logic [3:0]              m_axi_acsnoop;
  logic                    m_axi_acready;

  modport master (
    input  command_valid, command_store, command_rready, command_addr, data_in,
    output bus_valid, bus_ready, data_out, invalidate, invalidate_addr,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    input  m_axi_acvalid, m_axi_acaddr, m_axi_acsnoop,
    output m_axi_acready
  );

  modport slave (
    output command_valid, command_store, command_rready, command_addr, data_in,
    input  bus_valid, bus_ready, data_out, invalidate, invalidate_addr,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    output m_axi_acvalid, m_axi_acaddr, m_axi_acsnoop,
    input  m_axi_acready
  );

endinterface

// File: rtl/cache_memory_bus_snoop_relay.sv
// Registers every accepted AC snoop into a one-cycle invalidate pulse with its address.
module axi_snoop_relay #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  acvalid_i,
  input  logic [ADDR_WIDTH-1:0] acaddr_i,
  output logic                  invalidate_o,
  output logic [ADDR_WIDTH-1:0] invalidate_addr_o
);

  logic                  inval_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inval_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      inval_q <= acvalid_i;
      if (acvalid_i) addr_q <= acaddr_i;
    end
  end

  assign invalidate_o      = inval_q;
  assign invalidate_addr_o = addr_q;

endmodule

// File: rtl/cache_memory_bus.sv
// Fixed-priority arbiter and AXI4 burst master serving I/D cache line fills and writebacks.
// state | meaning
// IDLE  | arbitrate, latch client/address/line | AR/AW | address phase
// R     | collect 16 read beats                | W     | send 16 write beats
// B     | wait write response                  | DONE  | bus_valid until command_rready
module cache_memory_bus
  import cache_memory_bus_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  cache_memory_bus_if.master bus
);

  localparam int LINE = LINE_BEATS * DATA_WIDTH;

  state_e                state_q, state_d;
  logic                  client_q, client_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE-1:0]       wline_q, wline_d;
  logic [LINE-1:0]       rline_q, rline_d;
  logic [3:0]            beat_q, beat_d;
  logic [1:0]            ready_q, ready_d;

  // D-cache (bit 0) wins whenever it is requesting
  logic                             grant;
  logic [ADDR_WIDTH-LINE_OFFSET-1:0] sel_addr_hi;
  logic [LINE-1:0]                  sel_line;
  logic                             sel_store;
  logic                             sel_rready;

  assign grant       = ~bus.command_valid[0];
  assign sel_addr_hi = grant ? bus.command_addr[2*ADDR_WIDTH-1:ADDR_WIDTH+LINE_OFFSET]
                             : bus.command_addr[ADDR_WIDTH-1:LINE_OFFSET];
  assign sel_line    = grant ? bus.data_in[2*LINE-1:LINE] : bus.data_in[LINE-1:0];
  assign sel_store   = grant ? bus.command_store[1] : bus.command_store[0];
  assign sel_rready  = client_q ? bus.command_rready[1] : bus.command_rready[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      client_q <= 1'b0;
      addr_q   <= '0;
      wline_q  <= '0;
      rline_q  <= '0;
      beat_q   <= '0;
      ready_q  <= '0;
    end else begin
      state_q  <= state_d;
      client_q <= client_d;
      addr_q   <= addr_d;
      wline_q  <= wline_d;
      rline_q  <= rline_d;
      beat_q   <= beat_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    client_d = client_q;
    addr_d   = addr_q;
    wline_d  = wline_q;
    rline_d  = rline_q;
    beat_d   = beat_q;
    ready_d  = 2'b00;
    unique case (state_q)
      ST_IDLE: if (|bus.command_valid) begin
        client_d = grant;
        addr_d   = {sel_addr_hi, {LINE_OFFSET{1'b0}}};
        wline_d  = sel_line;
        beat_d   = '0;
        ready_d  = client_onehot(grant);
        state_d  = sel_store ? ST_AW : ST_AR;
      end
      ST_AR: if (bus.m_axi_arready) state_d = ST_R;
      ST_R: if (bus.m_axi_rvalid) begin
        rline_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = bus.m_axi_rdata;
        beat_d = beat_q + 4'd1;
        if (bus.m_axi_rlast) begin
          beat_d  = '0;
          state_d = ST_DONE;
        end
      end
      ST_AW: if (bus.m_axi_awready) state_d = ST_W;
      ST_W: if (bus.m_axi_wready) begin
        beat_d = beat_q + 4'd1;
        if (beat_q == 4'(LINE_BEATS - 1)) state_d = ST_B;
      end
      ST_B: if (bus.m_axi_bvalid) state_d = ST_DONE;
      ST_DONE: if (sel_rready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.m_axi_arvalid = (state_q == ST_AR);
  assign bus.m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, client_q};
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arlen   = AXI_LEN;
  assign bus.m_axi_arsize  = AXI_SIZE;
  assign bus.m_axi_arburst = BURST_INCR;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'b0;
  assign bus.m_axi_arprot  = 3'b0;
  assign bus.m_axi_rready  = (state_q == ST_R);

  assign bus.m_axi_awvalid = (state_q == ST_AW);
  assign bus.m_axi_awid    = {{(ID_WIDTH-1){1'b0}}, client_q};
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awlen   = AXI_LEN;
  assign bus.m_axi_awsize  = AXI_SIZE;
  assign bus.m_axi_awburst = BURST_INCR;
  assign bus.m_axi_awlock  = 1'b0;
  assign bus.m_axi_awcache = 4'b0;
  assign bus.m_axi_awprot  = 3'b0;

  assign bus.m_axi_wvalid  = (state_q == ST_W);
  assign bus.m_axi_wdata   = wline_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wlast   = (state_q == ST_W) && (beat_q == 4'(LINE_BEATS - 1));
  assign bus.m_axi_bready  = (state_q == ST_B);

  assign bus.bus_valid     = (state_q == ST_DONE) ? client_onehot(client_q) : 2'b00;
  assign bus.bus_ready     = ready_q;
  assign bus.data_out      = rline_q;
  assign bus.m_axi_acready = 1'b1;

  axi_snoop_relay #(.ADDR_WIDTH(ADDR_WIDTH)) u_snoop_relay (
    .clk               (clk),
    .reset             (reset),
    .acvalid_i         (bus.m_axi_acvalid),
    .acaddr_i          (bus.m_axi_acaddr),
    .invalidate_o      (bus.invalidate),
    .invalidate_addr_o (bus.invalidate_addr)
  );

  logic unused_inputs;
  assign unused_inputs = ^{bus.m_axi_bid, bus.m_axi_bresp, bus.m_axi_rid, bus.m_axi_rresp,
                           bus.m_axi_acsnoop,
                           bus.command_addr[ADDR_WIDTH+LINE_OFFSET-1:ADDR_WIDTH],
                           bus.command_addr[LINE_OFFSET-1:0]};

endmodule

// File: tb/tb_cache_memory_bus.sv
// Scoreboard bench for cache_memory_bus: fills, writebacks, arbitration, backpressure, snoop, reset.
module tb_cache_memory_bus;
  import cache_memory_bus_pkg::*;

  localparam int IW   = 13;
  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int LINE = 16 * DW;
  localparam logic [63:0] SNOOP_ADDR = 64'h3000_0040;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_memory_bus_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  cache_memory_bus #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc_cnt = 0;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pop_exp();
    if (exp_q.size() == 0) return 64'hDEAD_BEEF_DEAD_BEEF;
    return exp_q.pop_front();
  endfunction

  function automatic logic [LINE-1:0] make_line(input logic [63:0] base);
    logic [LINE-1:0] l;
    for (int k = 0; k < 16; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  task automatic idle_inputs();
    bus_if.command_valid  = '0;
    bus_if.command_store  = '0;
    bus_if.command_rready = '0;
    bus_if.command_addr   = '0;
    bus_if.data_in        = '0;
    bus_if.m_axi_awready  = 1'b0;
    bus_if.m_axi_wready   = 1'b0;
    bus_if.m_axi_bid      = '0;
    bus_if.m_axi_bresp    = '0;
    bus_if.m_axi_bvalid   = 1'b0;
    bus_if.m_axi_arready  = 1'b0;
    bus_if.m_axi_rid      = '0;
    bus_if.m_axi_rdata    = '0;
    bus_if.m_axi_rresp    = '0;
    bus_if.m_axi_rlast    = 1'b0;
    bus_if.m_axi_rvalid   = 1'b0;
    bus_if.m_axi_acvalid  = 1'b0;
    bus_if.m_axi_acaddr   = '0;
    bus_if.m_axi_acsnoop  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_handshake"}, 64'({bus_if.m_axi_arvalid, bus_if.m_axi_awvalid, bus_if.m_axi_wvalid,
                                   bus_if.m_axi_rready, bus_if.m_axi_bready, bus_if.bus_valid,
                                   bus_if.bus_ready, bus_if.invalidate}), 64'd0);
    check({tag, "_data_out"}, 64'(|bus_if.data_out), 64'd0);
    check({tag, "_inv_addr"}, bus_if.invalidate_addr, 64'd0);
  endtask

  task automatic issue(input int c, input bit store, input logic [63:0] addr,
                       input logic [LINE-1:0] line);
    bus_if.command_valid[c]        = 1'b1;
    bus_if.command_store[c]        = store;
    bus_if.command_addr[c*AW +: AW] = addr;
    bus_if.data_in[c*LINE +: LINE] = line;
    if (store) for (int k = 0; k < 16; k++) exp_q.push_back(line[k*64 +: 64]);
  endtask

  task automatic wait_grant(input int c);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = bus_if.bus_ready[c];
    end
    check("grant", 64'(seen), 64'd1);
    bus_if.command_valid[c] = 1'b0;
  endtask

  task automatic addr_phase(input int c, input bit store, input logic [63:0] exp_addr,
                            input int delay);
    for (int i = 0; i <= delay; i++) begin
      check("ax_valid", 64'(store ? bus_if.m_axi_awvalid : bus_if.m_axi_arvalid), 64'd1);
      check("ax_addr", store ? bus_if.m_axi_awaddr : bus_if.m_axi_araddr, exp_addr);
      if (i == 0) begin
        check("ax_len", 64'(store ? bus_if.m_axi_awlen : bus_if.m_axi_arlen), 64'd15);
        check("ax_id", 64'(store ? bus_if.m_axi_awid : bus_if.m_axi_arid), 64'(c));
        check("ax_size_burst", 64'(store ? {bus_if.m_axi_awsize, bus_if.m_axi_awburst}
                                         : {bus_if.m_axi_arsize, bus_if.m_axi_arburst}), 64'h0D);
      end
      if (i == 1) check("bus_ready_pulse", 64'(bus_if.bus_ready), 64'd0);
      if (i == delay) begin
        if (store) bus_if.m_axi_awready = 1'b1;
        else       bus_if.m_axi_arready = 1'b1;
      end
      @(negedge clk); #1;
    end
    bus_if.m_axi_arready = 1'b0;
    bus_if.m_axi_awready = 1'b0;
  endtask

  task automatic mid_reset();
    reset                = 1'b0;
    bus_if.m_axi_rvalid  = 1'b0;
    bus_if.m_axi_rlast   = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    @(negedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic read_data(input logic [63:0] base, input int snoop_at, input int reset_at);
    for (int k = 0; k < 16; k++) begin
      if (k == reset_at) begin
        mid_reset();
        return;
      end
      if (k == 0) check("rready", 64'(bus_if.m_axi_rready), 64'd1);
      if (k == snoop_at) begin
        bus_if.m_axi_acvalid = 1'b1;
        bus_if.m_axi_acaddr  = SNOOP_ADDR;
        bus_if.m_axi_acsnoop = 4'hB;
      end
      if (k == snoop_at + 1) begin
        bus_if.m_axi_acvalid = 1'b0;
        check("invalidate", 64'(bus_if.invalidate), 64'd1);
        check("inv_addr", bus_if.invalidate_addr, SNOOP_ADDR);
      end
      if (k == snoop_at + 2) check("invalidate_pulse", 64'(bus_if.invalidate), 64'd0);
      bus_if.m_axi_rvalid = 1'b1;
      bus_if.m_axi_rdata  = base + 64'(k);
      bus_if.m_axi_rlast  = (k == 15);
      bus_if.m_axi_rresp  = k[0] ? 2'b10 : 2'b00;
      exp_q.push_back(base + 64'(k));
      @(negedge clk); #1;
    end
    bus_if.m_axi_rvalid = 1'b0;
    bus_if.m_axi_rlast  = 1'b0;
  endtask

  task automatic release_client(input int c);
    bus_if.command_rready[c] = 1'b1;
    @(negedge clk); #1;
    bus_if.command_rready[c] = 1'b0;
    check("bus_valid_drop", 64'(bus_if.bus_valid), 64'd0);
  endtask

  task automatic finish_fill(input int c);
    check("bus_valid", 64'(bus_if.bus_valid), 64'(1 << c));
    for (int k = 0; k < 16; k++) check("fill_beat", bus_if.data_out[k*64 +: 64], pop_exp());
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("bus_valid_hold", 64'(bus_if.bus_valid), 64'(1 << c));
      check("no_early_ar", 64'(bus_if.m_axi_arvalid), 64'd0);
    end
    release_client(c);
  endtask

  task automatic write_data(input int c, input bit toggle);
    int n = 0;
    int cyc = 0;
    while (n < 16 && cyc < 100) begin
      bus_if.m_axi_wready = toggle ? cyc[0] : 1'b1;
      check("wvalid", 64'(bus_if.m_axi_wvalid), 64'd1);
      if (bus_if.m_axi_wready) begin
        check("wdata", bus_if.m_axi_wdata, pop_exp());
        check("wlast", 64'(bus_if.m_axi_wlast), 64'(n == 15));
        check("wstrb", 64'(bus_if.m_axi_wstrb), 64'hFF);
        n++;
      end else if (exp_q.size() != 0) begin
        check("wdata_hold", bus_if.m_axi_wdata, exp_q[0]);
      end
      cyc++;
      @(negedge clk); #1;
    end
    bus_if.m_axi_wready = 1'b0;
    check("w_beats", 64'(n), 64'd16);
    check("wvalid_after", 64'(bus_if.m_axi_wvalid), 64'd0);
    check("bready", 64'(bus_if.m_axi_bready), 64'd1);
    @(negedge clk); #1;
    check("wb_wait_b", 64'(bus_if.bus_valid), 64'd0);
    bus_if.m_axi_bvalid = 1'b1;
    @(negedge clk); #1;
    bus_if.m_axi_bvalid = 1'b0;
    check("bus_valid_wb", 64'(bus_if.bus_valid), 64'(1 << c));
    release_client(c);
  endtask

  initial begin
    int t0;
    idle_inputs();
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1;

    // D-cache fill, zero-wait slave, latency from request cycle to bus_valid
    t0 = cyc_cnt;
    issue(0, 1'b0, 64'h1000_0045, '0);
    wait_grant(0);
    addr_phase(0, 1'b0, 64'h1000_0000, 0);
    read_data(64'h0, 100, 100);
    check("fill_latency", 64'(cyc_cnt - t0), 64'd18);
    finish_fill(0);

    // I-cache writeback
    issue(1, 1'b1, 64'h2000_0080, make_line(64'hA0));
    wait_grant(1);
    addr_phase(1, 1'b1, 64'h2000_0080, 0);
    write_data(1, 1'b0);

    // simultaneous requests: D-cache first, I-cache after release
    issue(0, 1'b0, 64'h4000_0100, '0);
    issue(1, 1'b0, 64'h5000_0233, '0);
    wait_grant(0);
    check("i_pending", 64'(bus_if.bus_ready[1]), 64'd0);
    addr_phase(0, 1'b0, 64'h4000_0100, 0);
    read_data(64'h1111_0000, 100, 100);
    finish_fill(0);
    wait_grant(1);
    addr_phase(1, 1'b0, 64'h5000_0200, 0);
    read_data(64'h2222_0000, 100, 100);
    finish_fill(1);

    // backpressure: delayed arready, toggling wready
    issue(0, 1'b0, 64'h6000_0010, '0);
    wait_grant(0);
    addr_phase(0, 1'b0, 64'h6000_0000, 5);
    read_data(64'h3333_0000, 100, 100);
    finish_fill(0);
    issue(0, 1'b1, 64'h7000_0000, make_line(64'h5500));
    wait_grant(0);
    addr_phase(0, 1'b1, 64'h7000_0000, 2);
    write_data(0, 1'b1);

    // snoop during a read burst
    issue(1, 1'b0, 64'h8000_0000, '0);
    wait_grant(1);
    addr_phase(1, 1'b0, 64'h8000_0000, 0);
    read_data(64'h300, 4, 100);
    finish_fill(1);

    // reset at beat 7, then a normal fill
    issue(0, 1'b0, 64'h9000_0000, '0);
    wait_grant(0);
    addr_phase(0, 1'b0, 64'h9000_0000, 0);
    read_data(64'h100, 100, 7);
    issue(0, 1'b0, 64'h9000_0080, '0);
    wait_grant(0);
    addr_phase(0, 1'b0, 64'h9000_0080, 0);
    read_data(64'h500, 100, 100);
    finish_fill(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_memory_bus.md
# cache_memory_bus

Arbiter and AXI4 master that connects the instruction cache and the data cache to the system bus. It serves whole 128-byte cache-line fills and writebacks as 16-beat bursts of 64-bit data. It assembles read beats into one line and returns it to the requesting cache. It also turns AXI snoop (AC) requests into an invalidate pulse broadcast to both caches.

## Interface
- ID_WIDTH, 13, AXI ID width
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 64, AXI data width; line width LINE = 16*DATA_WIDTH
- STRB_WIDTH, DATA_WIDTH/8, write strobe width

Clocking and reset (already decided): one clock; reset is asynchronous and active-low.

- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- command_valid  in  2  per-client request; bit 1 is the I-cache, bit 0 is the D-cache (same ordering for every 2-bit or 2-slice port)
- command_store  in  2  1 = writeback, 0 = line fill
- command_rready  in  2  client acknowledges bus_valid
- command_addr  in  2*ADDR_WIDTH  request address; slice [1] is the upper half
- data_in  in  2*LINE  writeback line per client; beat k = bits [64k+63:64k]
- bus_valid  out  2  transaction complete; data_out is valid for a fill
- bus_ready  out  2  request accepted (1-cycle pulse)
- data_out  out  LINE  assembled fill line, shared by both clients
- invalidate  out  1  snoop invalidate pulse
- invalidate_addr  out  ADDR_WIDTH  snooped address
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}  out; awready  in
- m_axi_w{data,strb,last,valid}  out; wready  in
- m_axi_b{id,resp,valid}  in; bready  out
- m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}  out; arready  in
- m_axi_r{id,data,resp,last,valid}  in; rready  out
- m_axi_ac{valid,addr,snoop}  in; acready  out

## Operation
- **States:** IDLE, AR, R, AW, W, B, DONE.
- **IDLE:**
  - Grant uses fixed priority, D-cache (0) first, then I-cache (1).
  - On grant, latch the client index, the address aligned to 128 B (low 7 bits cleared) and that client's data_in slice.
  - Pulse bus_ready[g] for one cycle.
  - Go to AR if command_store=0, else AW.
- **AR:**
  - arvalid=1, araddr = latched address, arid = client index, arlen=15, arsize=3, arburst=INCR (2'b01).
  - arlock, arcache and arprot are 0.
  - On arready, go to R.
- **R:**
  - rready=1. Beat counter k from 0 to 15; each accepted beat writes line bits [64k+63:64k].
  - On rvalid&&rlast, go to DONE.
  - rresp is ignored.
- **AW:**
  - Same fields as AR on the AW channel.
  - On awready, go to W.
- **W:**
  - wvalid=1, wdata = beat k of the latched line, wstrb all ones, wlast when k=15.
  - k advances on wready.
  - After beat 15 is accepted, go to B.
- **B:**
  - bready=1. On bvalid, go to DONE.
- **DONE:**
  - bus_valid[g]=1. For a fill, data_out holds the line.
  - Hold until command_rready[g], then return to IDLE.
  - bus_valid of the non-granted client is always 0.
- **Snoop:**
  - acready is tied to 1.
  - Any acvalid registers acaddr into invalidate_addr and pulses invalidate for one cycle.
  - acsnoop is ignored.
  - Snoop handling is independent of the request state machine and never stalls it.

## Timing
- **Reset:** state IDLE and counters 0. Every valid, ready and pulse output is 0; data_out and invalidate_addr are 0.
- **Grant latency:** grant happens in the first IDLE cycle with command_valid set. arvalid or awvalid rises on the next cycle.
- **Minimum latency:** for a read with zero-wait slaves, the request cycle to bus_valid is 1 (AR) + 16 (R) + 1 cycles.
- **Valid hold:** arvalid, awvalid and wvalid stay high until their ready is seen; address and data are stable while waiting.
- **Simultaneous requests:** D-cache wins. The I-cache request stays pending and is served after DONE.
- **Request changes:** a request is never aborted. Client inputs that change after grant are ignored.
- **Reset during a burst:** reset asserted mid-burst immediately returns to IDLE with all outputs at reset values. No completion is signalled.
- **Snoop timing:** a snoop in cycle t gives invalidate=1 in cycle t+1, concurrent with any state.

## Structure
- **Shared package:** holds the state enum, the burst constants (LEN=15, SIZE=3, BURST_INCR) and LINE_BEATS=16.
- **Sub-module:** one sub-module, `axi_snoop_relay` (AC to invalidate register). Arbiter and burst FSM stay in the top.

## Test plan
- **D-cache fill:** D-cache fill of 0x1000_0045 -> araddr 0x1000_0000, arlen 15, arid 0. Beats 0..15 of value k get placed at [64k+:64]; bus_valid[0] is held until command_rready[0].
- **I-cache writeback:** I-cache writeback of 0x2000_0080 with line beats 0xA0+k -> 16 W beats in order, wlast only on beat 15, wstrb 0xFF. After bvalid, bus_valid[1] is asserted.
- **Simultaneous requests:** both clients request in the same cycle -> D-cache served first, then I-cache starts after the D-cache's command_rready.
- **Backpressure:** arready is delayed 5 cycles and wready toggles -> arvalid is held and address stable; no W beat is skipped or duplicated.
- **Snoop:** acvalid with acaddr 0x3000_0040 during an R burst -> invalidate pulses for exactly one cycle with invalidate_addr 0x3000_0040. The burst completes unaffected.
- **Reset mid-burst:** reset at beat 7 of a fill -> all outputs 0 and state IDLE. A new request afterwards completes normally.
